// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel front end: window FSM states,
// window geometry and the pixel width used by the delay lines.
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } win_state_e;

  localparam int WIN_SIZE = 3;
  localparam int PIX_W    = 16;

endpackage

// File: rtl/sobel_raster_cnt.sv
// Raster column/row counter: advances on inc, wraps the column at IMG_W-1,
// flags the last pixel of the frame and clears synchronously on clr.
module sobel_raster_cnt #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             line_end,
  output logic             last
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  assign line_end = (col == COL_MAX);
  assign last     = line_end && (row == ROW_MAX);

  // The last pixel returns the row to 0 rather than counting past IMG_H-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (inc) begin
      if (line_end) begin
        col <= '0;
        row <= last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Sobel front-end sequencer: raster tracking, delay-line shift enable and a
// registered window-valid output stage. Define SOBEL_WIN_BORDER_EN to also
// emit border windows (flagged by out_border).
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shift_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [COL_W-1:0] out_col,
  output logic [ROW_W-1:0] out_row,
  output logic             out_border,
  output logic             busy,
  output logic             frame_done,
  output win_state_e       state_dbg
);

  localparam int EDGE = WIN_SIZE - 1;

  win_state_e       state_q, state_d;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             line_end, last_pix;
  logic             active, border, qualify;

  // Handshakes: a beat moves when valid & ready are both high at a rising
  // edge; valid never waits on ready, and a presented output stays stable
  // until taken. Input ready is withheld whenever an untaken window is held.
  assign active     = (state_q == FILL) || (state_q == RUN);
  assign in_ready   = active && (!out_valid || out_ready);
  assign shift_en   = in_valid && in_ready;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign state_dbg  = state_q;
  assign border     = (row < ROW_W'(EDGE)) || (col < COL_W'(EDGE));

`ifdef SOBEL_WIN_BORDER_EN
  assign qualify = shift_en;
`else
  assign qualify = shift_en && !border;
`endif

  sobel_raster_cnt #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .COL_W(COL_W),
    .ROW_W(ROW_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!active),
    .inc     (shift_en),
    .col     (col),
    .row     (row),
    .line_end(line_end),
    .last    (last_pix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = FILL;
      FILL: if (shift_en && line_end && (row == ROW_W'(EDGE - 1))) state_d = RUN;
      RUN:  if (shift_en && last_pix) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A new qualifying accept reloads the register even while the old window
  // is being taken, so back-to-back windows leave no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_col   <= '0;
      out_row   <= '0;
    end else if (qualify) begin
      out_valid <= 1'b1;
      out_col   <= col;
      out_row   <= row;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SOBEL_WIN_BORDER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       out_border <= 1'b0;
    else if (qualify) out_border <= border;
  end
`else
  assign out_border = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl: a 4x3 instance for directed
// scenarios and a 5x4 instance for randomized handshakes.
module tb_sobel_window_ctrl;
  import sobel_pkg::*;

  localparam int AW = 4, AH = 3, BW = 5, BH = 4;

  logic clk = 1'b0, rst_n = 1'b0;

  logic start_a = 1'b0, in_valid_a = 1'b0, out_ready_a = 1'b0;
  logic a_in_ready, a_shift_en, a_out_valid, a_out_border, a_busy, a_frame_done;
  logic [1:0] a_out_col, a_out_row;
  win_state_e a_state;

  logic start_b = 1'b0, in_valid_b = 1'b0, out_ready_b = 1'b0;
  logic b_in_ready, b_shift_en, b_out_valid, b_out_border, b_busy, b_frame_done;
  logic [2:0] b_out_col;
  logic [1:0] b_out_row;
  win_state_e b_state;

  int vectors = 0, miscompares = 0;
  int xfer_a = 0, xfer_b = 0;
  logic [15:0] exp_a_q[$], exp_b_q[$];
  logic [15:0] act_a, exp_a, act_b, exp_b;

  always #5 clk = ~clk;

  sobel_window_ctrl #(.IMG_W(AW), .IMG_H(AH)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid_a),
    .in_ready(a_in_ready), .shift_en(a_shift_en), .out_valid(a_out_valid),
    .out_ready(out_ready_a), .out_col(a_out_col), .out_row(a_out_row),
    .out_border(a_out_border), .busy(a_busy), .frame_done(a_frame_done),
    .state_dbg(a_state)
  );

  sobel_window_ctrl #(.IMG_W(BW), .IMG_H(BH)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid_b),
    .in_ready(b_in_ready), .shift_en(b_shift_en), .out_valid(b_out_valid),
    .out_ready(out_ready_b), .out_col(b_out_col), .out_row(b_out_row),
    .out_border(b_out_border), .busy(b_busy), .frame_done(b_frame_done),
    .state_dbg(b_state)
  );

  // Reference model: which raster positions produce a window and what it reports.
  function automatic bit qualifies(int r, int c);
`ifdef SOBEL_WIN_BORDER_EN
    return 1'b1;
`else
    return (r >= 2) && (c >= 2);
`endif
  endfunction

  function automatic logic [15:0] win_word(int r, int c);
    logic b;
`ifdef SOBEL_WIN_BORDER_EN
    b = (r < 2) || (c < 2);
`else
    b = 1'b0;
`endif
    return {r[7:0], c[6:0], b};
  endfunction

  function automatic int frame_outputs(int w, int h);
`ifdef SOBEL_WIN_BORDER_EN
    return w * h;
`else
    return (w - 2) * (h - 2);
`endif
  endfunction

  task automatic push_frame_a();
    for (int r = 0; r < AH; r++)
      for (int c = 0; c < AW; c++)
        if (qualifies(r, c)) exp_a_q.push_back(win_word(r, c));
  endtask

  task automatic push_frame_b();
    for (int r = 0; r < BH; r++)
      for (int c = 0; c < BW; c++)
        if (qualifies(r, c)) exp_b_q.push_back(win_word(r, c));
  endtask

  // Scoreboards: a window transfers at the edge after valid & ready are seen.
  always @(negedge clk) begin
    #3;
    if (rst_n === 1'b1 && a_out_valid === 1'b1 && out_ready_a === 1'b1) begin
      act_a = {8'(a_out_row), 7'(a_out_col), a_out_border};
      vectors++;
      xfer_a++;
      if (exp_a_q.size() == 0) begin
        miscompares++;
        $display("FAIL a_window_extra got=%h required=none", act_a);
      end else begin
        exp_a = exp_a_q.pop_front();
        if (act_a !== exp_a) begin
          miscompares++;
          $display("FAIL a_window got=%h required=%h", act_a, exp_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    #3;
    if (rst_n === 1'b1 && b_out_valid === 1'b1 && out_ready_b === 1'b1) begin
      act_b = {8'(b_out_row), 7'(b_out_col), b_out_border};
      vectors++;
      xfer_b++;
      if (exp_b_q.size() == 0) begin
        miscompares++;
        $display("FAIL b_window_extra got=%h required=none", act_b);
      end else begin
        exp_b = exp_b_q.pop_front();
        if (act_b !== exp_b) begin
          miscompares++;
          $display("FAIL b_window got=%h required=%h", act_b, exp_b);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    vectors++;
    if ({a_in_ready, a_shift_en, a_out_valid, a_out_border, a_busy, a_frame_done,
         a_out_col, a_out_row} !== 10'b0 || a_state !== IDLE) begin
      miscompares++;
      $display("FAIL %s_a got=%b%b%b%b%b%b col=%0d row=%0d required=all zero", tag,
               a_in_ready, a_shift_en, a_out_valid, a_out_border, a_busy,
               a_frame_done, a_out_col, a_out_row);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    vectors++;
    if ({b_in_ready, b_shift_en, b_out_valid, b_out_border, b_busy, b_frame_done,
         b_out_col, b_out_row} !== 11'b0 || b_state !== IDLE) begin
      miscompares++;
      $display("FAIL reset_b got=%b%b%b col=%0d row=%0d required=all zero",
               b_in_ready, b_out_valid, b_busy, b_out_col, b_out_row);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid_a = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (a_in_ready !== 1'b0 || a_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_ready got in_ready=%b busy=%b required=0,0", a_in_ready, a_busy);
    end
  endtask

  // Runs one 4x3 frame with in_valid/out_ready high, checking output latency,
  // frame_done timing and the busy fall; optionally pulses start mid-frame and in DONE.
  task automatic run_frame_a(input bit mid_start, input bit done_start);
    int accepts = 0, last_acc = -10, n0, r, c;
    bit done_seen = 1'b0, pend = 1'b0;
    logic [15:0] pend_w = '0;
    in_valid_a = 1'b1;
    out_ready_a = 1'b1;
    push_frame_a();
    n0 = xfer_a;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    #1;
    vectors++;
    if (a_in_ready !== 1'b1 || a_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_to_ready got in_ready=%b busy=%b required=1,1", a_in_ready, a_busy);
    end
    for (int cyc = 0; cyc < 60 && !done_seen; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        #1;
      end
      start_a = 1'b0;
      vectors++;
      if (pend) begin
        if (a_out_valid !== 1'b1 || {8'(a_out_row), 7'(a_out_col), a_out_border} !== pend_w) begin
          miscompares++;
          $display("FAIL out_latency got v=%b r=%0d c=%0d b=%b required=%h",
                   a_out_valid, a_out_row, a_out_col, a_out_border, pend_w);
        end
      end else if (a_out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL spurious_valid got=%b required=0", a_out_valid);
      end
      pend = 1'b0;
      if (a_frame_done === 1'b1) begin
        done_seen = 1'b1;
        vectors++;
        if (accepts != AW * AH || cyc != last_acc + 1) begin
          miscompares++;
          $display("FAIL frame_done_timing got accepts=%0d gap=%0d required=%0d,1",
                   accepts, cyc - last_acc, AW * AH);
        end
        start_a = done_start;
      end else if (a_shift_en === 1'b1) begin
        r = accepts / AW;
        c = accepts % AW;
        pend = qualifies(r, c);
        pend_w = win_word(r, c);
        accepts++;
        last_acc = cyc;
        if (mid_start && accepts == 3) start_a = 1'b1;
      end
    end
    if (!done_seen) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_done_timeout got accepts=%0d required=%0d", accepts, AW * AH);
    end
    @(negedge clk);
    #1;
    start_a = 1'b0;
    vectors++;
    if (a_busy !== 1'b0 || a_frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_fall got busy=%b frame_done=%b required=0,0", a_busy, a_frame_done);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (a_busy !== 1'b0 || a_in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL start_in_done got busy=%b in_ready=%b required=0,0", a_busy, a_in_ready);
    end
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (xfer_a - n0 != frame_outputs(AW, AH) || exp_a_q.size() != 0) begin
      miscompares++;
      $display("FAIL frame_count got=%0d left=%0d required=%0d,0",
               xfer_a - n0, exp_a_q.size(), frame_outputs(AW, AH));
    end
  endtask

  task automatic test_basic_frame();
    run_frame_a(1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    int n0;
    bit seen = 1'b0, done_seen = 1'b0;
    logic [1:0] hr, hc;
    logic hb;
    logic [15:0] head;
    in_valid_a = 1'b1;
    out_ready_a = 1'b1;
    push_frame_a();
    n0 = xfer_a;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      #1;
      if (a_out_valid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL bp_valid_timeout got=0 required=1");
    end
    out_ready_a = 1'b0;
    #1;
    hr = a_out_row;
    hc = a_out_col;
    hb = a_out_border;
    head = (exp_a_q.size() > 0) ? exp_a_q[0] : 16'hffff;
    vectors++;
    if ({8'(hr), 7'(hc), hb} !== head) begin
      miscompares++;
      $display("FAIL bp_first_window got=%h required=%h", {8'(hr), 7'(hc), hb}, head);
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (a_in_ready !== 1'b0 || a_shift_en !== 1'b0 || a_out_valid !== 1'b1 ||
          a_out_row !== hr || a_out_col !== hc) begin
        miscompares++;
        $display("FAIL bp_hold got rdy=%b sh=%b v=%b r=%0d c=%0d required=0,0,1,%0d,%0d",
                 a_in_ready, a_shift_en, a_out_valid, a_out_row, a_out_col, hr, hc);
      end
      @(negedge clk);
      #1;
    end
    out_ready_a = 1'b1;
    for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
      @(negedge clk);
      #1;
      if (a_frame_done === 1'b1) done_seen = 1'b1;
    end
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (!done_seen || xfer_a - n0 != frame_outputs(AW, AH) || exp_a_q.size() != 0) begin
      miscompares++;
      $display("FAIL bp_resume got done=%b count=%0d left=%0d required=1,%0d,0",
               done_seen, xfer_a - n0, exp_a_q.size(), frame_outputs(AW, AH));
    end
  endtask

  task automatic test_reset_mid();
    int accepts = 0;
    in_valid_a = 1'b1;
    out_ready_a = 1'b1;
    push_frame_a();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int cyc = 0; cyc < 40 && accepts < 6; cyc++) begin
      #1;
      if (a_shift_en === 1'b1) accepts++;
      @(negedge clk);
    end
    vectors++;
    if (accepts != 6) begin
      miscompares++;
      $display("FAIL reset_mid_reach got=%0d required=6", accepts);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    exp_a_q.delete();
    in_valid_a = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    run_frame_a(1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_frame_a(1'b1, 1'b1);
    run_frame_a(1'b0, 1'b0);
  endtask

  task automatic test_random_b();
    int n0;
    bit done_seen = 1'b0;
    push_frame_b();
    n0 = xfer_b;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int cyc = 0; cyc < 2000 && !done_seen; cyc++) begin
      in_valid_b = 1'($urandom_range(0, 1));
      out_ready_b = 1'($urandom_range(0, 1));
      #1;
      if (b_frame_done === 1'b1) done_seen = 1'b1;
      if (b_out_valid === 1'b1 && out_ready_b === 1'b0) begin
        vectors++;
        if (b_in_ready !== 1'b0 || b_shift_en !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_stall got in_ready=%b shift_en=%b required=0,0", b_in_ready, b_shift_en);
        end
      end
      @(negedge clk);
    end
    in_valid_b = 1'b0;
    out_ready_b = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    vectors++;
    if (!done_seen || xfer_b - n0 != frame_outputs(BW, BH) || exp_b_q.size() != 0) begin
      miscompares++;
      $display("FAIL rand_frame got done=%b count=%0d left=%0d required=1,%0d,0",
               done_seen, xfer_b - n0, exp_b_q.size(), frame_outputs(BW, BH));
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_reset_mid();
    test_start_ignored();
    test_random_b();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
